// File: rtl/uart_tx_ctrl.sv
// Purpose: UART transmit sequencer; latches a byte and drives the output mux select frame by frame.
// Latency: Data_Valid at edge N gives START in cycle N+1 and the first data bit in cycle N+2.
// Backpressure: busy high for the whole frame; Data_Valid ignored while busy (accepted in STOP with UART_TX_BACK2BACK_EN).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  accept;

  // Acceptance window: IDLE always, STOP too when back-to-back frames are enabled
  always_comb begin
    accept = 1'b0;
`ifdef UART_TX_BACK2BACK_EN
    if ((state == IDLE || state == STOP) && Data_Valid) accept = 1'b1;
`else
    if (state == IDLE && Data_Valid) accept = 1'b1;
`endif
  end

  // Frame sequencing: start, data bits, optional parity, stop
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   next_state = DATA;
      DATA:    if (bit_cnt == CNT_LAST) next_state = par_en_q ? PARITY : STOP;
      PARITY:  next_state = STOP;
      STOP:    next_state = accept ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight and returns the line to idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Payload, parity and bit counter; the counter holds on the last bit so it never wraps
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
    end else if (accept) begin
      shift_reg <= P_DATA;
      bit_cnt   <= '0;
      par_en_q  <= PAR_EN;
      par_bit   <= (^P_DATA) ^ PAR_TYP;
    end else if (state == DATA) begin
      shift_reg <= shift_reg >> 1;
      if (bit_cnt != CNT_LAST) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Mux select and busy are pure decodes of the registered state
  always_comb begin
    mux_sel = 2'b01;
    busy    = 1'b0;
    case (state)
      START:   begin mux_sel = 2'b00; busy = 1'b1; end
      DATA:    begin mux_sel = 2'b10; busy = 1'b1; end
      PARITY:  begin mux_sel = 2'b11; busy = 1'b1; end
      STOP:    begin mux_sel = 2'b01; busy = 1'b1; end
      default: begin mux_sel = 2'b01; busy = 1'b0; end
    endcase
  end

  assign ser_data = shift_reg[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Purpose: self-checking bench for uart_tx_ctrl against a frame-level queue model.
// Latency: model pushes a whole frame's expected line cycles at the accepting edge.
// Backpressure: requests while the model's frame queue is busy are dropped, as on the line.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [1:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One expected line cycle: select, busy, and the data bit when it is a data cycle
  typedef struct packed {
    logic [1:0] ms;
    logic       bz;
    logic       is_data;
    logic       bit_v;
  } cyc_t;

  cyc_t q[$];
  logic exp_par;
  int   n_acc;
  logic acc;
  cyc_t cur;

  function automatic void push_frame(input logic [DW-1:0] d, input logic pe);
    q.push_back('{ms: 2'b00, bz: 1'b1, is_data: 1'b0, bit_v: 1'b0});
    for (int i = 0; i < DW; i++)
      q.push_back('{ms: 2'b10, bz: 1'b1, is_data: 1'b1, bit_v: d[i]});
    if (pe) q.push_back('{ms: 2'b11, bz: 1'b1, is_data: 1'b0, bit_v: 1'b0});
    q.push_back('{ms: 2'b01, bz: 1'b1, is_data: 1'b0, bit_v: 1'b0});
  endfunction

  // Reference model: a frame is a list of line cycles; each edge consumes one
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      exp_par = 1'b0;
    end else begin
      acc = (q.size() == 0) && Data_Valid;
`ifdef UART_TX_BACK2BACK_EN
      if (q.size() == 1 && Data_Valid) acc = 1'b1;
`endif
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        push_frame(P_DATA, PAR_EN);
        exp_par = (^P_DATA) ^ PAR_TYP;
        n_acc++;
      end
    end
  end

  // Line monitor on the falling edge
  always @(negedge CLK) begin
    if (RST) begin
      if (q.size() > 0) cur = q[0];
      else cur = '{ms: 2'b01, bz: 1'b0, is_data: 1'b0, bit_v: 1'b0};
      chk("mux_sel", 32'(mux_sel), 32'(cur.ms));
      chk("busy", 32'(busy), 32'(cur.bz));
      chk("par_bit", 32'(par_bit), 32'(exp_par));
      if (cur.is_data) chk("ser_data", 32'(ser_data), 32'(cur.bit_v));
    end
  end

  task automatic do_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pulse(input logic [DW-1:0] d, input logic pe, input logic pt);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    do_cyc();
    Data_Valid = 1'b0;
  endtask

  // Counts busy cycles of the frame in flight, bounded
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask

  int nb;
  int gaps;
  int acc0;
  int exp_gap;

  initial begin
    RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    n_acc = 0;
    repeat (3) do_cyc();
    chk("rst_mux", 32'(mux_sel), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_par", 32'(par_bit), 32'h0);
    RST = 1'b1;
    repeat (6) do_cyc();

    // 8N1 frame of 0xA5
    send_pulse(8'hA5, 1'b0, 1'b0);
    count_busy(nb);
    chk("len_8n1", 32'(nb), 32'd10);

    // 8E1 and 8O1
    send_pulse(8'hA5, 1'b1, 1'b0);
    chk("par_even", 32'(par_bit), 32'h0);
    count_busy(nb);
    chk("len_8e1", 32'(nb), 32'd11);
    send_pulse(8'hA5, 1'b1, 1'b1);
    chk("par_odd", 32'(par_bit), 32'h1);
    count_busy(nb);
    chk("len_8o1", 32'(nb), 32'd11);

    // Request during DATA is ignored and inputs may change freely mid-frame
    send_pulse(8'h3C, 1'b0, 1'b0);
    repeat (3) do_cyc();
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    do_cyc();
    Data_Valid = 1'b0;
    count_busy(nb);
    chk("len_ignored", 32'(nb), 32'd6);
    chk("acc_count", 32'(n_acc), 32'd4);

    // Held request across two frames
    repeat (2) do_cyc();
    acc0 = n_acc;
    gaps = 0;
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    do_cyc();
    P_DATA = 8'h80;
    for (int i = 0; i < 30; i++) begin
      do_cyc();
      if (!busy) gaps++;
      if (n_acc >= acc0 + 2) break;
    end
    Data_Valid = 1'b0;
`ifdef UART_TX_BACK2BACK_EN
    exp_gap = 0;
`else
    exp_gap = 1;
`endif
    chk("b2b_accepts", 32'(n_acc - acc0), 32'd2);
    chk("b2b_gap", 32'(gaps), 32'(exp_gap));
    count_busy(nb);

    // Reset during the 4th data bit
    repeat (2) do_cyc();
    send_pulse(8'h5A, 1'b1, 1'b0);
    repeat (4) do_cyc();
    chk("pre_rst_mux", 32'(mux_sel), 32'h2);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_mux", 32'(mux_sel), 32'h1);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_par", 32'(par_bit), 32'h0);
    do_cyc();
    #2 RST = 1'b1;
    repeat (6) do_cyc();

    // Randomized traffic with inputs churning every cycle
    for (int i = 0; i < 400; i++) begin
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Data_Valid = ($urandom_range(0, 9) < 3);
      do_cyc();
    end
    Data_Valid = 1'b0;
    repeat (15) do_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side control and datapath stage of the UART transmitter, placed directly upstream of the output-select mux. It accepts a parallel byte with a valid strobe and latches it. It computes the optional parity bit, serializes the data LSB-first and sequences the frame (start, data, optional parity, stop) by driving the mux select. One serial bit is sent per `CLK` cycle, so `CLK` runs at the baud rate.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame (≥2).
- `CLK` in 1: bit-rate clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `P_DATA` in DATA_WIDTH: parallel payload; sampled only when a frame is accepted.
- `Data_Valid` in 1: request to send `P_DATA`; single-cycle or level.
- `PAR_EN` in 1: 1 = parity bit included in frame; sampled at acceptance.
- `PAR_TYP` in 1: 0 = even, 1 = odd; sampled at acceptance.
- `mux_sel` out 2: mux select. 00 = start, 01 = stop/idle, 10 = serial data, 11 = parity.
- `ser_data` out 1: current data bit (`shift_reg[0]`).
- `par_bit` out 1: parity of latched payload.
- `busy` out 1: high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state register is the only source of `mux_sel` and `busy`; both are pure decodes of the registered state.
- State decodes:
  - IDLE: `mux_sel`=01 (line high), `busy`=0.
  - START: 00.
  - DATA: 10.
  - PARITY: 11.
  - START/DATA/PARITY/STOP all drive `busy`=1.
- Acceptance happens in IDLE when `Data_Valid`=1. On that edge:
  - `P_DATA` loads into the shift register.
  - `PAR_EN` and `PAR_TYP` are latched.
  - `par_bit` <= ^`P_DATA` ^ `PAR_TYP`.
  - The bit counter clears to 0.
  - Next state is START.
- START lasts 1 cycle, then goes to DATA.
- DATA lasts DATA_WIDTH cycles. The shift register shifts right by 1 at the end of each DATA cycle, and the bit counter increments. When the counter reaches DATA_WIDTH-1, the next state is PARITY if latched `PAR_EN`=1, else STOP.
- PARITY lasts 1 cycle, then goes to STOP.
- STOP lasts 1 cycle, then goes to IDLE (see Configuration for back-to-back).
- `Data_Valid` is ignored in START/DATA/PARITY. `P_DATA`, `PAR_EN` and `PAR_TYP` may change freely mid-frame with no effect.
- Bit counter width is $clog2(DATA_WIDTH). It never wraps within a frame.

## Timing
- Reset values (asserted asynchronously, immediately, including mid-frame):
  - state IDLE, `mux_sel`=01, `busy`=0.
  - `ser_data`=0, `par_bit`=0.
  - shift register 0, counter 0, latched config 0.
- After reset the line is high, and the aborted frame is not resumed.
- Latency: `Data_Valid` sampled high at edge N gives START (`mux_sel`=00, `busy`=1) during cycle N+1.
- The first data bit is on the line in cycle N+2.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 cycles. This is 10 for 8N1 and 11 for 8E1/8O1.
- `busy` falls in the cycle after STOP (IDLE), unless back-to-back applies.
- Minimum inter-frame gap with the macro off is 1 IDLE cycle. The earliest next acceptance is the edge ending that IDLE cycle.

## Configuration
- `UART_TX_BACK2BACK_EN` defined:
  - In STOP, `Data_Valid`=1 accepts a new frame with the same latching as IDLE, and the next state is START.
  - `busy` stays high continuously, with zero gap between stop and the next start.
- Not defined:
  - STOP always goes to IDLE, and `Data_Valid` in STOP is ignored.
  - A request held high across STOP is accepted in the following IDLE cycle.

## Test plan
- Reset with `RST`=0, then release. Required: `mux_sel`=01, `busy`=0, `par_bit`=0, and the line idles high for ≥5 cycles with `Data_Valid`=0.
- `P_DATA`=0xA5, `PAR_EN`=0, pulse `Data_Valid`. Required:
  - `mux_sel` sequence 00, 10×8, 01.
  - `ser_data` in DATA cycles 1,0,1,0,0,1,0,1.
  - `busy` high for exactly 10 cycles.
- 0xA5 with `PAR_EN`=1. Required:
  - `PAR_TYP`=0 gives `par_bit`=0; `PAR_TYP`=1 gives `par_bit`=1.
  - PARITY state (`mux_sel`=11) appears after the 8th data bit.
  - `busy` is high for 11 cycles.
- 0x3C, then pulse `Data_Valid` with 0xFF during DATA. Required: the second request is ignored, the frame carries 0x3C (`ser_data` 0,0,1,1,1,1,0,0), and the line returns to IDLE.
- Hold `Data_Valid` high for two frames, 0x01 then 0x80. Required:
  - Macro off: one IDLE cycle (`mux_sel`=01, `busy`=0) between STOP and START.
  - Macro on: START immediately follows STOP and `busy` never drops.
- Assert `RST`=0 during the 4th data bit. Required: `mux_sel`=01 and `busy`=0 immediately, with no partial-frame continuation after release.
